// File: rtl/fft_reorder_buf.sv
// Ping-pong frame buffer that reorders bit-reversed FFT output into natural order
// (or passes order through) and streams it downstream under valid/ready.
module fft_reorder_buf #(
    parameter int DATA_WIDTH = 16,
    parameter int MAX_STEP   = 9,
    parameter int BITREV     = 1
) (
    input  logic                  iclk,
    input  logic                  rst,
    input  logic [3:0]            cfg_step,
    input  logic                  ien,
    input  logic [DATA_WIDTH-1:0] iReal,
    input  logic [DATA_WIDTH-1:0] iImag,
    output logic                  iready,
    output logic                  oen,
    output logic [DATA_WIDTH-1:0] oReal,
    output logic [DATA_WIDTH-1:0] oImag,
    output logic                  olast,
    input  logic                  oready,
    output logic                  cfg_err
);

    localparam int         DEPTH    = 1 << MAX_STEP;
    localparam int         WW       = 2 * DATA_WIDTH;
    localparam logic [3:0] STEP_MAX = 4'(MAX_STEP);

    typedef enum logic [0:0] {R_IDLE, R_RUN} rstate_t;

    function automatic logic [MAX_STEP-1:0] last_idx(input logic [3:0] step);
        logic [MAX_STEP:0] n;
        n = ({{MAX_STEP{1'b0}}, 1'b1} << step) - {{MAX_STEP{1'b0}}, 1'b1};
        return n[MAX_STEP-1:0];
    endfunction

    // idx < 2^step, so reversing the full word and shifting down reverses the low step bits
    function automatic logic [MAX_STEP-1:0] bit_rev(input logic [MAX_STEP-1:0] idx,
                                                    input logic [3:0]          step);
        logic [MAX_STEP-1:0] full;
        for (int i = 0; i < MAX_STEP; i++) begin
            full[i] = idx[MAX_STEP-1-i];
        end
        return full >> (STEP_MAX - step);
    endfunction

    logic [WW-1:0]       mem0 [DEPTH];
    logic [WW-1:0]       mem1 [DEPTH];
    logic [WW-1:0]       rdata_r;

    logic                wr_bank_r, iready_r, cfg_err_r;
    logic [MAX_STEP-1:0] wc_r;
    logic [1:0]          full_r;
    logic [3:0]          step_r [2];

    logic                accept_s, first_s, cfg_bad_s, wr_done_s, wr_bank_n_s;
    logic [3:0]          cfg_clamp_s, wstep_s, rstep_s;
    logic [MAX_STEP-1:0] waddr_s;
    logic [1:0]          full_s;

    rstate_t             state_r, state_n;
    logic                rd_bank_r;
    logic [MAX_STEP-1:0] rc_r;
    logic                p_v_r, p_last_r;
    logic                out_v_r, out_last_r, skid_v_r, skid_last_r;
    logic [WW-1:0]       out_d_r, skid_d_r;
    logic                rlast_s, bank_ready_s, pop_s, credit_s, issue_s, free_s;
    logic [1:0]          occ_s;

    // Write-side decode and next bank occupancy
    always_comb begin
        accept_s    = ien & iready_r;
        first_s     = (wc_r == {MAX_STEP{1'b0}});
        cfg_bad_s   = (cfg_step == 4'd0) | (cfg_step > STEP_MAX);
        cfg_clamp_s = cfg_bad_s ? STEP_MAX : cfg_step;
        wstep_s     = first_s ? cfg_clamp_s : step_r[wr_bank_r];
        wr_done_s   = accept_s & (wc_r == last_idx(wstep_s));
        waddr_s     = (BITREV != 0) ? bit_rev(wc_r, wstep_s) : wc_r;
        wr_bank_n_s = wr_bank_r ^ wr_done_s;
        full_s      = full_r;
        full_s[wr_bank_r] = full_r[wr_bank_r] | wr_done_s;
        // a bank is released once its last word has left memory; the tail rides in the pipeline
        full_s[rd_bank_r] = (wr_done_s & (wr_bank_r == rd_bank_r)) | (full_r[rd_bank_r] & ~free_s);
    end

    // Write counter, bank flags, per-bank step and input-ready register
    always_ff @(posedge iclk or posedge rst) begin
        if (rst) begin
            wr_bank_r <= 1'b0;
            wc_r      <= {MAX_STEP{1'b0}};
            full_r    <= 2'b00;
            step_r[0] <= 4'd0;
            step_r[1] <= 4'd0;
            iready_r  <= 1'b0;
            cfg_err_r <= 1'b0;
        end else begin
            if (accept_s) begin
                wc_r <= wr_done_s ? {MAX_STEP{1'b0}} : wc_r + MAX_STEP'(1);
            end
            if (accept_s && first_s) begin
                step_r[wr_bank_r] <= cfg_clamp_s;
            end
            cfg_err_r <= accept_s & first_s & cfg_bad_s;
            full_r    <= full_s;
            wr_bank_r <= wr_bank_n_s;
            iready_r  <= ~full_s[wr_bank_n_s];
        end
    end

    // Bank storage: one write port, one synchronous read port
    always_ff @(posedge iclk) begin
        if (accept_s && !wr_bank_r) mem0[waddr_s] <= {iReal, iImag};
        if (accept_s && wr_bank_r)  mem1[waddr_s] <= {iReal, iImag};
        if (issue_s) rdata_r <= rd_bank_r ? mem1[rc_r] : mem0[rc_r];
    end

    // Read issue gating: a bank completing this cycle may be read at once (addr 0 is long written)
    always_comb begin
        rstep_s      = step_r[rd_bank_r];
        rlast_s      = (rc_r == last_idx(rstep_s));
        bank_ready_s = full_r[rd_bank_r] | (wr_done_s & (wr_bank_r == rd_bank_r));
        pop_s        = out_v_r & oready;
        occ_s        = {1'b0, out_v_r} + {1'b0, skid_v_r} + {1'b0, p_v_r};
        credit_s     = (occ_s < 2'd2) | ((occ_s == 2'd2) & pop_s);
        free_s       = issue_s & rlast_s;
    end

    // Read FSM next state and read issue
    always_comb begin
        state_n = state_r;
        issue_s = 1'b0;
        case (state_r)
            R_IDLE: begin
                if (bank_ready_s && credit_s) begin
                    issue_s = 1'b1;
                    state_n = R_RUN;
                end else begin
                    state_n = R_IDLE;
                end
            end
            R_RUN: begin
                if (!bank_ready_s) begin
                    state_n = R_IDLE;
                end else begin
                    issue_s = credit_s;
                    state_n = R_RUN;
                end
            end
            default: state_n = R_IDLE;
        endcase
    end

    // Read counter, read-data tracking, output register and skid stage
    always_ff @(posedge iclk or posedge rst) begin
        if (rst) begin
            state_r     <= R_IDLE;
            rd_bank_r   <= 1'b0;
            rc_r        <= {MAX_STEP{1'b0}};
            p_v_r       <= 1'b0;
            p_last_r    <= 1'b0;
            out_v_r     <= 1'b0;
            out_last_r  <= 1'b0;
            out_d_r     <= {WW{1'b0}};
            skid_v_r    <= 1'b0;
            skid_last_r <= 1'b0;
            skid_d_r    <= {WW{1'b0}};
        end else begin
            state_r  <= state_n;
            p_v_r    <= issue_s;
            p_last_r <= issue_s & rlast_s;
            if (issue_s) begin
                rc_r      <= rlast_s ? {MAX_STEP{1'b0}} : rc_r + MAX_STEP'(1);
                rd_bank_r <= rd_bank_r ^ rlast_s;
            end
            if (!out_v_r || pop_s) begin
                if (skid_v_r) begin
                    out_v_r     <= 1'b1;
                    out_d_r     <= skid_d_r;
                    out_last_r  <= skid_last_r;
                    skid_v_r    <= p_v_r;
                    skid_d_r    <= rdata_r;
                    skid_last_r <= p_last_r;
                end else if (p_v_r) begin
                    out_v_r    <= 1'b1;
                    out_d_r    <= rdata_r;
                    out_last_r <= p_last_r;
                end else begin
                    out_v_r    <= 1'b0;
                    out_last_r <= 1'b0;
                end
            end else if (p_v_r) begin
                skid_v_r    <= 1'b1;
                skid_d_r    <= rdata_r;
                skid_last_r <= p_last_r;
            end
        end
    end

    assign iready  = iready_r;
    assign cfg_err = cfg_err_r;
    assign oen     = out_v_r;
    assign olast   = out_last_r;
    assign oReal   = out_d_r[WW-1:DATA_WIDTH];
    assign oImag   = out_d_r[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_fft_reorder_buf.sv
// Randomized bench for fft_reorder_buf: frames go through a queue-based reorder model
// and every output beat is compared against it.
module tb_fft_reorder_buf;

    localparam int DW = 16;
    localparam int MS = 9;

    logic          iclk = 1'b0;
    logic          rst;
    logic [3:0]    cfg_step;
    logic          ien, iready, oen, olast, oready, cfg_err;
    logic [DW-1:0] iReal, iImag, oReal, oImag;
    logic          ien_b, iready_b, oen_b, olast_b, oready_b, cfg_err_b;
    logic [DW-1:0] oReal_b, oImag_b;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          or_mode = 0;
    int          err_cnt, first_oen_cyc, last_acc_cyc, first_pop_cyc, last_pop_cyc, pop_cnt, stall_cnt;
    logic [32:0] exp_q [$];
    logic [32:0] mon_e, hold_val;
    logic        hold_v = 1'b0;

    fft_reorder_buf #(.DATA_WIDTH(DW), .MAX_STEP(MS), .BITREV(1)) dut (
        .iclk(iclk), .rst(rst), .cfg_step(cfg_step), .ien(ien), .iReal(iReal), .iImag(iImag),
        .iready(iready), .oen(oen), .oReal(oReal), .oImag(oImag), .olast(olast),
        .oready(oready), .cfg_err(cfg_err));

    fft_reorder_buf #(.DATA_WIDTH(DW), .MAX_STEP(MS), .BITREV(0)) dut_b (
        .iclk(iclk), .rst(rst), .cfg_step(cfg_step), .ien(ien_b), .iReal(iReal), .iImag(iImag),
        .iready(iready_b), .oen(oen_b), .oReal(oReal_b), .oImag(oImag_b), .olast(olast_b),
        .oready(oready_b), .cfg_err(cfg_err_b));

    always #5 iclk = ~iclk;

    always @(posedge iclk) cyc++;

    always @(posedge iclk) begin
        #2;
        case (or_mode)
            0:       oready = 1'b1;
            1:       oready = 1'($urandom_range(1));
            default: oready = 1'b0;
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int brev(input int k, input int s);
        int r = 0;
        int v = k;
        for (int i = 0; i < s; i++) begin
            r = r * 2 + (v % 2);
            v = v / 2;
        end
        return r;
    endfunction

    // Output monitor: scoreboard compare, hold stability, cfg_err pulse counting
    always @(negedge iclk) begin
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (cfg_err) err_cnt++;
            if (hold_v) chk("hold_stable", {oen, olast, oReal, oImag}, {1'b1, hold_val});
            if (oen && first_oen_cyc < 0) first_oen_cyc = cyc;
            if (oen && oready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("out_data", {oReal, oImag}, mon_e[31:0]);
                    chk("out_last", olast, mon_e[32]);
                end
                if (pop_cnt == 0) first_pop_cyc = cyc;
                last_pop_cyc = cyc;
                pop_cnt++;
            end
            hold_v   = oen && !oready;
            hold_val = {olast, oReal, oImag};
        end
    end

    task automatic send_frame(input logic [3:0] step, input int gap_pct, input bit pattern);
        int eff, n, k, guard;
        bit acc;
        logic [31:0] d [$];
        eff = (step == 4'd0 || step > 4'(MS)) ? MS : int'(step);
        n = 1 << eff;
        for (int i = 0; i < n; i++) begin
            if (pattern) d.push_back({16'(brev(i, eff)), 16'(brev(i, eff))});
            else d.push_back($urandom);
        end
        for (int j = 0; j < n; j++) exp_q.push_back({(j == n - 1), d[brev(j, eff)]});
        k = 0;
        guard = 0;
        while (k < n && guard < 4000) begin
            if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                ien = 1'b0;
            end else begin
                ien = 1'b1;
                cfg_step = (k == 0) ? step : 4'($urandom_range(15));
                {iReal, iImag} = d[k];
            end
            acc = ien && iready;
            if (ien && !iready) stall_cnt++;
            if (acc) last_acc_cyc = cyc;
            @(posedge iclk); #1;
            if (acc) k++;
            guard++;
        end
        ien = 1'b0;
        if (k < n) chk("send_timeout", k, n);
    endtask

    task automatic drain();
        int g = 0;
        while (exp_q.size() > 0 && g < 5000) begin
            @(posedge iclk); #1;
            g++;
        end
        chk("drain_empty", exp_q.size(), 0);
        repeat (4) @(posedge iclk);
        #1;
    endtask

    initial begin
        int extra, got, k, g;
        bit acc;
        logic [31:0] din [8];

        rst = 1'b1; ien = 1'b0; ien_b = 1'b0; oready_b = 1'b0; oready = 1'b1;
        cfg_step = 4'd3; iReal = '0; iImag = '0;
        err_cnt = 0; first_oen_cyc = -1; pop_cnt = 0; stall_cnt = 0;
        #23;
        chk("rst_iready", iready, 0);
        chk("rst_outs", {oen, olast, oReal, oImag, cfg_err}, 0);
        @(negedge iclk) rst = 1'b0;
        @(posedge iclk); #1;
        chk("iready_after_rst", iready, 1);

        // bit-reversed ramp comes out as 0..7, two cycles after the last input
        first_oen_cyc = -1; pop_cnt = 0;
        send_frame(4'd3, 0, 1'b1);
        drain();
        chk("latency", first_oen_cyc - last_acc_cyc, 2);
        chk("ramp_contig", last_pop_cyc - first_pop_cyc, 7);

        // three back-to-back 32-point frames
        pop_cnt = 0; stall_cnt = 0;
        repeat (3) send_frame(4'd5, 0, 1'b0);
        drain();
        chk("b2b_no_stall", stall_cnt, 0);
        chk("b2b_count", pop_cnt, 96);
        chk("b2b_contig", last_pop_cyc - first_pop_cyc, 95);

        // back-pressure: both banks fill, then drain in order
        or_mode = 2;
        send_frame(4'd3, 0, 1'b0);
        send_frame(4'd3, 0, 1'b0);
        extra = 0;
        repeat (20) begin
            ien = 1'b1;
            if (iready) extra++;
            @(posedge iclk); #1;
        end
        ien = 1'b0;
        chk("bp_accept_extra", extra, 0);
        chk("bp_iready_low", iready, 0);
        chk("bp_oen_held", oen, 1);
        or_mode = 0;
        pop_cnt = 0;
        drain();
        chk("bp_drain_count", pop_cnt, 16);

        // frame size change
        pop_cnt = 0;
        send_frame(4'd3, 0, 1'b0);
        send_frame(4'd2, 0, 1'b0);
        drain();
        chk("size_chg_count", pop_cnt, 12);

        // out-of-range steps clamp to 512 points
        err_cnt = 0;
        send_frame(4'd0, 0, 1'b0);
        drain();
        chk("cfg_err_zero", err_cnt, 1);
        send_frame(4'd12, 10, 1'b0);
        drain();
        chk("cfg_err_big", err_cnt, 2);

        // random sizes, gaps and back-pressure
        or_mode = 1;
        for (int f = 0; f < 8; f++) send_frame(4'($urandom_range(6, 1)), 30, 1'b0);
        drain();
        or_mode = 0;
        chk("rand_no_err", err_cnt, 2);

        // reset in the middle of a frame
        for (int i = 0; i < 5; i++) begin
            ien = 1'b1; cfg_step = 4'd3; {iReal, iImag} = $urandom;
            @(posedge iclk); #1;
        end
        ien = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("midrst_iready", iready, 0);
        chk("midrst_outs", {oen, olast, oReal, oImag, cfg_err}, 0);
        exp_q.delete();
        @(negedge iclk) rst = 1'b0;
        @(posedge iclk); #1;
        pop_cnt = 0;
        send_frame(4'd3, 0, 1'b0);
        drain();
        chk("midrst_count", pop_cnt, 8);

        // in-order variant behaves as a frame FIFO
        for (int i = 0; i < 8; i++) din[i] = $urandom;
        k = 0; g = 0;
        while (k < 8 && g < 50) begin
            ien_b = 1'b1; cfg_step = 4'd3; {iReal, iImag} = din[k];
            acc = iready_b;
            @(posedge iclk); #1;
            if (acc) k++;
            g++;
        end
        ien_b = 1'b0;
        oready_b = 1'b1;
        got = 0; g = 0;
        while (got < 8 && g < 100) begin
            @(negedge iclk);
            if (oen_b) begin
                chk("fifo_data", {oReal_b, oImag_b}, din[got]);
                chk("fifo_last", olast_b, (got == 7));
                got++;
            end
            g++;
        end
        chk("fifo_count", got, 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
